pwm_duty_decoder: RTL

- Receive-side counterpart of the PWM brightness generator. Measures an incoming PWM waveform and reports its high time and period in clock cycles.
- Sits between an external or looped-back PWM line and status/readback logic, so generated brightness can be checked against the commanded duty.
- Input is treated as asynchronous. Detects loss of signal, i.e. a constant-level line at 0% or 100% duty.

---
 rtl/pwm_duty_decoder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pwm_duty_decoder.sv
// Measures high time and rise-to-rise period of an asynchronous PWM line.
// Optional glitch filter on the synchronised line: define GLITCH_FILTER_EN.
module pwm_duty_decoder #(
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = 200,
    parameter int FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] duty_out,
    output logic [CNT_W-1:0] period_out,
    output logic             meas_valid,
    output logic             no_signal,
    output logic             line_level
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    if (TIMEOUT < 2 || TIMEOUT > (2**CNT_W) - 1) begin : g_bad_timeout
        $error("pwm_duty_decoder: TIMEOUT must lie in 2 .. 2**CNT_W-1");
    end
    if (FILT_LEN < 1) begin : g_bad_filt_len
        $error("pwm_duty_decoder: FILT_LEN must be at least 1");
    end

    // Counter never wraps: it parks at TIMEOUT so a dead line is always detectable.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= TIMEOUT_C) begin
            return TIMEOUT_C;
        end
        return v + CNT_W'(1);
    endfunction

    logic   sync_p0;
    logic   sync_p1;
    logic   pwm_s;
    logic   lvl;
    logic   lvl_d;
    logic   rise;
    logic   fall;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_cap;

    // Stage p0/p1: two-flop synchroniser for the asynchronous line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= pwm_in;
            sync_p1 <= sync_p0;
        end
    end

    assign pwm_s = sync_p1;

`ifdef GLITCH_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);

    logic [FW-1:0] filt_cnt;
    logic          lvl_f;

    // Filter stage: lvl follows pwm_s only after FILT_LEN consecutive disagreeing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_f    <= 1'b0;
            filt_cnt <= '0;
        end else if (pwm_s != lvl_f) begin
            if (filt_cnt == FILT_LAST) begin
                lvl_f    <= pwm_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    assign lvl = lvl_f;
`else
    assign lvl = pwm_s;
`endif

    // Edge stage: one-cycle delayed copy of the line for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_d <= 1'b0;
        end else begin
            lvl_d <= lvl;
        end
    end

    assign rise       = lvl & ~lvl_d;
    assign fall       = ~lvl & lvl_d;
    assign line_level = lvl;

    // Measurement stage: counter, FSM and published results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            hi_cap     <= '0;
            duty_out   <= '0;
            period_out <= '0;
            meas_valid <= 1'b0;
            no_signal  <= 1'b1;
        end else begin
            meas_valid <= 1'b0;
            cnt        <= rise ? CNT_W'(1) : sat_inc(cnt);

            case (state)
                IDLE: begin
                    // The period in progress when we start listening is never complete.
                    if (rise) begin
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state  <= LOW;
                        hi_cap <= cnt;
                    end else if (cnt == TIMEOUT_C) begin
                        state     <= IDLE;
                        no_signal <= 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state      <= HIGH;
                        duty_out   <= hi_cap;
                        period_out <= cnt;
                        no_signal  <= 1'b0;
                        meas_valid <= 1'b1;
                    end else if (cnt == TIMEOUT_C) begin
                        state     <= IDLE;
                        no_signal <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
